alu_share_arb: RTL and testbench

Two-requester arbiter and sequencer for the shared 4-bit ALU. It accepts operation requests from two independent clients over valid/ready handshakes and grants them round-robin. It runs the granted operation through one combinational ALU core, registers the result and flags, and returns them over a single tagged response channel. It sits between the ALU datapath and the two front-end controllers that previously each needed a private ALU.

---
 rtl/alu_share_pkg.sv | 23 ++
 rtl/alu_share_arb_alu_core.sv | 50 +++++
 rtl/alu_share_arb.sv | 144 ++++++++++++++
 tb/tb_alu_share_arb.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_pkg.sv
// Shared types for the two-client ALU arbiter: opcodes, FSM states, opcode width.
package alu_share_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_NOT = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4,
    OP_XOR = 3'd5,
    OP_GT  = 3'd6,
    OP_EQ  = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_share_arb_alu_core.sv
// Purely combinational W-bit ALU core: (op, a, b) -> (y, cf, of).
module alu_core
  import alu_share_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [OP_W-1:0] op_i,
  input  logic [W-1:0]    a_i,
  input  logic [W-1:0]    b_i,
  output logic [W-1:0]    y_o,
  output logic            cf_o,
  output logic            of_o
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W:0]   sum;
  logic [W:0]   dif;
  logic [W-1:0] b_neg;

  always_comb begin
    // Two's-complement negate so SUB by zero yields CF=0 (0 + A never carries).
    b_neg = ~b_i + ONE;
    sum   = {1'b0, a_i} + {1'b0, b_i};
    dif   = {1'b0, a_i} + {1'b0, b_neg};
    y_o   = '0;
    cf_o  = 1'b0;
    of_o  = 1'b0;
    case (opcode_e'(op_i))
      OP_ADD: begin
        y_o  = sum[W-1:0];
        cf_o = sum[W];
        of_o = (a_i[W-1] == b_i[W-1]) && (sum[W-1] != a_i[W-1]);
      end
      OP_SUB: begin
        y_o  = dif[W-1:0];
        cf_o = dif[W];
        of_o = (a_i[W-1] != b_i[W-1]) && (dif[W-1] != a_i[W-1]);
      end
      OP_NOT: y_o = ~a_i;
      OP_AND: y_o = a_i & b_i;
      OP_OR:  y_o = a_i | b_i;
      OP_XOR: y_o = a_i ^ b_i;
      OP_GT:  y_o = {{(W-1){1'b0}}, ($signed(a_i) > $signed(b_i))};
      OP_EQ:  y_o = {{(W-1){1'b0}}, (a_i == b_i)};
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin arbiter and sequencer sharing one ALU between two clients.
// Optional per-client response counters when ALU_SHARE_ARB_STATS_EN is defined.
//   state   | meaning
//   ST_IDLE | ready to grant a pending request
//   ST_EXEC | ALU evaluating latched operands
//   ST_RESP | result held on resp_* until accepted
module alu_share_arb
  import alu_share_pkg::*;
#(
  parameter int W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [OP_W-1:0] req0_op,
  input  logic [W-1:0]    req0_a,
  input  logic [W-1:0]    req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [OP_W-1:0] req1_op,
  input  logic [W-1:0]    req1_a,
  input  logic [W-1:0]    req1_b,
`ifdef ALU_SHARE_ARB_STATS_EN
  output logic [7:0]      stat0_cnt,
  output logic [7:0]      stat1_cnt,
`endif
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic            resp_id,
  output logic [W-1:0]    resp_y,
  output logic            resp_cf,
  output logic            resp_of
);

  state_e          state_q, state_d;
  logic            ptr_q;
  logic            id_q;
  logic [OP_W-1:0] op_q;
  logic [W-1:0]    a_q, b_q;
  logic            resp_valid_q, resp_id_q, resp_cf_q, resp_of_q;
  logic [W-1:0]    resp_y_q;
  logic            gnt_id;
  logic            accept;
  logic            resp_hs;
  logic [W-1:0]    alu_y;
  logic            alu_cf, alu_of;

  // Pointer only matters on contention; a lone requester always wins.
  assign gnt_id  = (req0_valid && req1_valid) ? ptr_q : req1_valid;
  assign accept  = (state_q == ST_IDLE) && (req0_valid || req1_valid);
  assign resp_hs = resp_valid_q && resp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)  state_d = ST_EXEC;
      ST_EXEC:              state_d = ST_RESP;
      ST_RESP: if (resp_hs) state_d = ST_IDLE;
      default:              state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state_q == ST_IDLE) begin
      req0_ready = req0_valid && !gnt_id;
      req1_ready = req1_valid &&  gnt_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
      id_q  <= 1'b0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else if (accept) begin
      ptr_q <= ~gnt_id;
      id_q  <= gnt_id;
      op_q  <= gnt_id ? req1_op : req0_op;
      a_q   <= gnt_id ? req1_a  : req0_a;
      b_q   <= gnt_id ? req1_b  : req0_b;
    end
  end

  alu_core #(.W(W)) u_alu_core (
    .op_i (op_q),
    .a_i  (a_q),
    .b_i  (b_q),
    .y_o  (alu_y),
    .cf_o (alu_cf),
    .of_o (alu_of)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_y_q     <= '0;
      resp_cf_q    <= 1'b0;
      resp_of_q    <= 1'b0;
    end else if (state_q == ST_EXEC) begin
      resp_valid_q <= 1'b1;
      resp_id_q    <= id_q;
      resp_y_q     <= alu_y;
      resp_cf_q    <= alu_cf;
      resp_of_q    <= alu_of;
    end else if (resp_hs) begin
      resp_valid_q <= 1'b0;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_y     = resp_y_q;
  assign resp_cf    = resp_cf_q;
  assign resp_of    = resp_of_q;

`ifdef ALU_SHARE_ARB_STATS_EN
  logic [7:0] stat0_q, stat1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat0_q <= '0;
      stat1_q <= '0;
    end else if (resp_hs) begin
      if (!resp_id_q && stat0_q != 8'hFF) stat0_q <= stat0_q + 8'd1;
      if ( resp_id_q && stat1_q != 8'hFF) stat1_q <= stat1_q + 8'd1;
    end
  end

  assign stat0_cnt = stat0_q;
  assign stat1_cnt = stat1_q;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed self-checking bench for alu_share_arb (stats counters checked when
// ALU_SHARE_ARB_STATS_EN is defined).
module tb_alu_share_arb;
  import alu_share_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [2:0]   req0_op = '0, req1_op = '0;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         resp_valid, resp_ready = 1'b0, resp_id, resp_cf, resp_of;
  logic [W-1:0] resp_y;
`ifdef ALU_SHARE_ARB_STATS_EN
  logic [7:0]   stat0_cnt, stat1_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_share_arb #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
`ifdef ALU_SHARE_ARB_STATS_EN
    .stat0_cnt  (stat0_cnt),
    .stat1_cnt  (stat1_cnt),
`endif
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_y     (resp_y),
    .resp_cf    (resp_cf),
    .resp_of    (resp_of)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input int who, input logic [2:0] op,
                           input logic [W-1:0] a, input logic [W-1:0] b);
    if (who == 0) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end
  endtask

  // Issue one request, check exact latency and the registered response.
  task automatic run_op(input string tag, input int who, input logic [2:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ey, input logic ecf, input logic eof);
    int  cnt;
    logic rdy;
    @(negedge clk);
    drive_req(who, op, a, b);
    #1;
    cnt = 0;
    rdy = (who == 0) ? req0_ready : req1_ready;
    while (!rdy && cnt < 20) begin
      @(negedge clk); #1;
      rdy = (who == 0) ? req0_ready : req1_ready;
      cnt++;
    end
    chk({tag, "_accept"}, {31'd0, rdy}, 32'd1);
    @(posedge clk); #1;
    if (who == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    chk({tag, "_exec_valid"}, {31'd0, resp_valid}, 32'd0);
    @(posedge clk); #1;
    chk({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
    chk({tag, "_id"}, {31'd0, resp_id}, who);
    chk({tag, "_y"}, {28'd0, resp_y}, {28'd0, ey});
    chk({tag, "_cf"}, {31'd0, resp_cf}, {31'd0, ecf});
    chk({tag, "_of"}, {31'd0, resp_of}, {31'd0, eof});
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk({tag, "_done"}, {31'd0, resp_valid}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_r0"}, {31'd0, req0_ready}, 32'd0);
    chk({tag, "_r1"}, {31'd0, req1_ready}, 32'd0);
    chk({tag, "_v"},  {31'd0, resp_valid}, 32'd0);
    chk({tag, "_id"}, {31'd0, resp_id}, 32'd0);
    chk({tag, "_y"},  {28'd0, resp_y}, 32'd0);
    chk({tag, "_cf"}, {31'd0, resp_cf}, 32'd0);
    chk({tag, "_of"}, {31'd0, resp_of}, 32'd0);
  endtask

  task automatic producer(input int who, input logic [2:0] op0, input logic [W-1:0] a0,
                          input logic [W-1:0] b0, input logic [2:0] op1,
                          input logic [W-1:0] a1, input logic [W-1:0] b1);
    int  cnt;
    logic rdy;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) drive_req(who, op0, a0, b0); else drive_req(who, op1, a1, b1);
      #1;
      cnt = 0;
      rdy = (who == 0) ? req0_ready : req1_ready;
      while (!rdy && cnt < 40) begin
        @(negedge clk); #1;
        rdy = (who == 0) ? req0_ready : req1_ready;
        cnt++;
      end
      chk($sformatf("rr_accept%0d_%0d", who, k), {31'd0, rdy}, 32'd1);
      @(posedge clk); #1;
    end
    if (who == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  logic [W-1:0] exp_y [4];
  logic         exp_id[4];
  int           got;
  int           cyc;

  initial begin
    #2;
    check_all_zero("rst");
`ifdef ALU_SHARE_ARB_STATS_EN
    chk("rst_stat0", {24'd0, stat0_cnt}, 32'd0);
    chk("rst_stat1", {24'd0, stat1_cnt}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Round robin from reset with both clients contending.
    exp_id = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_y  = '{4'd3, 4'd6, 4'd4, 4'd9};
    got = 0;
    @(negedge clk);
    resp_ready = 1'b1;
    fork
      producer(0, OP_ADD, 4'd1, 4'd2, OP_ADD, 4'd2, 4'd2);
      producer(1, OP_XOR, 4'd5, 4'd3, OP_OR,  4'd8, 4'd1);
      begin
        cyc = 0;
        while (got < 4 && cyc < 60) begin
          @(negedge clk);
          if (resp_valid) begin
            chk($sformatf("rr_id%0d", got), {31'd0, resp_id}, {31'd0, exp_id[got]});
            chk($sformatf("rr_y%0d", got), {28'd0, resp_y}, {28'd0, exp_y[got]});
            got++;
          end
          cyc++;
        end
        chk("rr_count", got, 32'd4);
      end
    join
    @(negedge clk);
    resp_ready = 1'b0;

    run_op("add", 0, OP_ADD, 4'd7, 4'd1, 4'd8, 1'b0, 1'b1);
    run_op("sub", 1, OP_SUB, 4'd3, 4'd5, 4'd14, 1'b0, 1'b0);
    run_op("sub0", 1, OP_SUB, 4'd5, 4'd0, 4'd5, 1'b0, 1'b0);
    run_op("subc", 0, OP_SUB, 4'd5, 4'd3, 4'd2, 1'b1, 1'b0);
    run_op("gt", 0, OP_GT, 4'b1000, 4'b0001, 4'd0, 1'b0, 1'b0);
    run_op("gtp", 0, OP_GT, 4'd3, 4'b1111, 4'd1, 1'b0, 1'b0);
    run_op("eq", 1, OP_EQ, 4'd9, 4'd9, 4'd1, 1'b0, 1'b0);
    run_op("and", 0, OP_AND, 4'd12, 4'd10, 4'd8, 1'b0, 1'b0);
    run_op("addcf", 1, OP_ADD, 4'd15, 4'd2, 4'd1, 1'b1, 1'b0);

    // Backpressure: resp_ready low for 5 cycles while req1 waits.
    @(negedge clk);
    drive_req(0, OP_XOR, 4'd12, 4'd10);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    drive_req(1, OP_NOT, 4'd5, 4'd0);
    @(posedge clk); #1;
    chk("bp_rise", {31'd0, resp_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_v%0d", i), {31'd0, resp_valid}, 32'd1);
      chk($sformatf("bp_y%0d", i), {28'd0, resp_y}, 32'd6);
      chk($sformatf("bp_id%0d", i), {31'd0, resp_id}, 32'd0);
      chk($sformatf("bp_r0_%0d", i), {31'd0, req0_ready}, 32'd0);
      chk($sformatf("bp_r1_%0d", i), {31'd0, req1_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("bp_hs", {31'd0, resp_valid}, 32'd0);
    chk("bp_next_ready", {31'd0, req1_ready}, 32'd1);
    run_op("not", 1, OP_NOT, 4'd5, 4'd0, 4'd10, 1'b0, 1'b0);

    // Reset during EXEC: everything clears at once, no response later.
    run_op("pre_rst", 1, OP_OR, 4'd3, 4'd4, 4'd7, 1'b0, 1'b0);
    @(negedge clk);
    drive_req(0, OP_ADD, 4'd7, 4'd7);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst_v%0d", i), {31'd0, resp_valid}, 32'd0);
    end
    resp_ready = 1'b0;

`ifdef ALU_SHARE_ARB_STATS_EN
    for (int i = 0; i < 300; i++) run_op("stat", 0, OP_AND, 4'd15, 4'd3, 4'd3, 1'b0, 1'b0);
    #1;
    chk("stat0_sat", {24'd0, stat0_cnt}, 32'd255);
    chk("stat1_zero", {24'd0, stat1_cnt}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
